// File: rtl/matrix_transpose_stream_pkg.sv
// Shared types and sizing for the streaming matrix transpose engine.
//   DATA_WIDTH : element width, passed through unchanged
//   MAX_DIM    : largest supported row/column count
//   DIM_W      : dimension field width (2**DIM_W > MAX_DIM)
package matrix_transpose_stream_pkg;

  localparam int unsigned DATA_WIDTH = 9;
  localparam int unsigned MAX_DIM    = 5;
  localparam int unsigned DIM_W      = 3;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [DIM_W-1:0]      dim_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One output beat: element plus end-of-matrix marker.
  typedef struct packed {
    data_t data;
    logic  last;
  } out_beat_t;

  // A dimension is usable when it is 1..MAX_DIM.
  function automatic logic dim_legal(input dim_t d);
    return (d != '0) && (d <= DIM_W'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matrix_transpose_stream_if.sv
// Control, source stream, result stream and status bundle of the transpose engine.
//   master : request side (drives start/dims, source elements, out_ready)
//   slave  : engine side (drives in_ready, result stream, dims and status)
interface matrix_transpose_stream_if;
  import matrix_transpose_stream_pkg::*;

  logic  start;
  dim_t  rows_in;
  dim_t  cols_in;
  logic  in_valid;
  data_t in_data;
  logic  in_ready;
  logic  out_valid;
  data_t out_data;
  logic  out_ready;
  logic  out_last;
  dim_t  rows_out;
  dim_t  cols_out;
  logic  busy;
  logic  done;
  logic  err;

  modport master (
    output start, rows_in, cols_in, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, rows_out, cols_out, busy, done, err
  );

  modport slave (
    input  start, rows_in, cols_in, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, rows_out, cols_out, busy, done, err
  );

endinterface

// File: rtl/matrix_transpose_stream_buffer.sv
// MAX_DIM x MAX_DIM element register file: one synchronous write port,
// one combinational read port, both addressed by (row, col).
//   clk              : write clock
//   wr_en/row/col    : write strobe and address
//   wr_data          : element to store
//   rd_row/rd_col    : read address
//   rd_data_c        : element at the read address (combinational)
module matrix_transpose_stream_buffer
  import matrix_transpose_stream_pkg::*;
(
  input  logic  clk,
  input  logic  wr_en,
  input  dim_t  wr_row,
  input  dim_t  wr_col,
  input  data_t wr_data,
  input  dim_t  rd_row,
  input  dim_t  rd_col,
  output data_t rd_data_c
);

  // Contents are don't-care after reset, so storage carries no reset.
  data_t mem [MAX_DIM][MAX_DIM];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row][wr_col] <= wr_data;
  end

  assign rd_data_c = mem[rd_row][rd_col];

endmodule

// File: rtl/matrix_transpose_stream.sv
// Element-serial matrix transpose: loads an R x C matrix row-major, then
// streams its C x R transpose row-major with valid/ready flow control.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of the control/stream/status bundle
module matrix_transpose_stream
  import matrix_transpose_stream_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  matrix_transpose_stream_if.slave    bus
);

  state_t    state_q, state_d;
  dim_t      rows_q, rows_d;
  dim_t      cols_q, cols_d;
  // cnt_a: source row during load, result row (k) during emit.
  // cnt_b: source col during load, result col (m) during emit.
  dim_t      cnt_a_q, cnt_a_d;
  dim_t      cnt_b_q, cnt_b_d;
  logic      in_ready_q, in_ready_d;
  logic      out_valid_q, out_valid_d;
  out_beat_t out_q, out_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      err_q, err_d;

  logic      in_hs_c;
  logic      out_hs_c;
  logic      wr_en_c;
  data_t     rd_data_c;

  assign in_hs_c  = bus.in_valid & in_ready_q;
  assign out_hs_c = out_valid_q & bus.out_ready;

  // Load writes buf[i][j]; emit reads buf[m][k] for result element (k, m).
  matrix_transpose_stream_buffer u_buf (
    .clk       (clk),
    .wr_en     (wr_en_c),
    .wr_row    (cnt_a_q),
    .wr_col    (cnt_b_q),
    .wr_data   (bus.in_data),
    .rd_row    (cnt_b_q),
    .rd_col    (cnt_a_q),
    .rd_data_c (rd_data_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    err_d       = 1'b0;
    wr_en_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (dim_legal(bus.rows_in) && dim_legal(bus.cols_in)) begin
            rows_d     = bus.rows_in;
            cols_d     = bus.cols_in;
            cnt_a_d    = '0;
            cnt_b_d    = '0;
            in_ready_d = 1'b1;
            state_d    = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (in_hs_c) begin
          wr_en_c = 1'b1;
          if (cnt_b_q == cols_q - DIM_W'(1)) begin
            cnt_b_d = '0;
            if (cnt_a_q == rows_q - DIM_W'(1)) begin
              cnt_a_d    = '0;
              in_ready_d = 1'b0;
              state_d    = ST_EMIT;
            end else begin
              cnt_a_d = cnt_a_q + DIM_W'(1);
            end
          end else begin
            cnt_b_d = cnt_b_q + DIM_W'(1);
          end
        end
      end

      ST_EMIT: begin
        if (out_hs_c && out_q.last) begin
          out_valid_d = 1'b0;
          out_d.last  = 1'b0;
          state_d     = ST_DONE;
        end else if (!out_valid_q || out_hs_c) begin
          // Fill the output register when empty or when its beat is taken.
          out_valid_d = 1'b1;
          out_d.data  = rd_data_c;
          out_d.last  = (cnt_a_q == cols_q - DIM_W'(1)) &&
                        (cnt_b_q == rows_q - DIM_W'(1));
          if (cnt_b_q == rows_q - DIM_W'(1)) begin
            cnt_b_d = '0;
            cnt_a_d = out_d.last ? '0 : cnt_a_q + DIM_W'(1);
          end else begin
            cnt_b_d = cnt_b_q + DIM_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_LOAD) || (state_d == ST_EMIT);
    done_d = (state_d == ST_DONE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q.data;
  assign bus.out_last  = out_q.last;
  assign bus.rows_out  = cols_q;
  assign bus.cols_out  = rows_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Self-checking bench for matrix_transpose_stream: directed shapes plus
// randomized jobs compared against a transpose model built from queues.
module tb_matrix_transpose_stream;
  import matrix_transpose_stream_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_transpose_stream_if bus();

  matrix_transpose_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_vec = 0;
  int    n_err = 0;
  data_t src_mem [MAX_DIM*MAX_DIM];
  data_t exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.out_valid, bus.out_last, bus.out_data, bus.in_ready,
                bus.busy, bus.done, bus.err, bus.rows_out, bus.cols_out});
  endfunction

  // in_mode: 0 valid always, 1 valid every other cycle, 2 random
  // out_mode: 0 ready always, 1 ready 1010.., 2 random
  // abort_after >= 0: assert reset once that many beats were accepted
  task automatic run_job(input int r, input int c, input int in_mode, input int out_mode,
                         input bit intrude, input int abort_after);
    int    n;
    int    idx;
    int    budget;
    int    ticks;
    bit    stalled;
    bit    hs;
    logic  v;
    logic  rdy;
    data_t held_d;
    logic  held_l;

    n = r * c;
    exp_q.delete();
    for (int k = 0; k < c; k++)
      for (int m = 0; m < r; m++)
        exp_q.push_back(src_mem[m*c + k]);

    bus.rows_in = DIM_W'(r);
    bus.cols_in = DIM_W'(c);
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_load", 32'(bus.busy), 1);
    chk("rows_out", 32'(bus.rows_out), 32'(c));
    chk("cols_out", 32'(bus.cols_out), 32'(r));

    ticks = 0; idx = 0; budget = 0;
    while (idx < n && budget < 500) begin
      case (in_mode)
        0:       v = 1'b1;
        1:       v = (budget % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? src_mem[idx] : DATA_WIDTH'($urandom);
      if (intrude && budget == 1) begin
        bus.start   = 1'b1;
        bus.rows_in = DIM_W'(1);
        bus.cols_in = DIM_W'(1);
      end else begin
        bus.start = 1'b0;
      end
      chk("in_ready_load", 32'(bus.in_ready), 1);
      hs = v && bus.in_ready;
      tick();
      ticks++; budget++;
      if (hs) idx++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (idx < n) chk("load_timeout", 32'(idx), 32'(n));
    chk("in_ready_emit", 32'(bus.in_ready), 0);
    chk("first_emit_gap", 32'(bus.out_valid), 0);

    idx = 0; budget = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (idx < n && budget < 500) begin
      if (abort_after >= 0 && idx == abort_after && budget > 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_zero", all_outs(), 0);
        bus.out_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("no_partial_out", 32'(bus.out_valid), 0);
        tick();
        chk("idle_after_rst", all_outs(), 0);
        return;
      end
      case (out_mode)
        0:       rdy = 1'b1;
        1:       rdy = (budget % 2) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (stalled) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_data", 32'(bus.out_data), 32'(held_d));
        chk("stall_last", 32'(bus.out_last), 32'(held_l));
      end
      if (bus.out_valid && rdy) begin
        chk("out_data", 32'(bus.out_data), 32'(exp_q[idx]));
        chk("out_last", 32'(bus.out_last), 32'(idx == n - 1));
        idx++;
      end
      stalled = bus.out_valid && !rdy;
      held_d  = bus.out_data;
      held_l  = bus.out_last;
      tick();
      ticks++; budget++;
    end
    bus.out_ready = 1'b0;
    if (idx < n) chk("emit_timeout", 32'(idx), 32'(n));
    chk("done_pulse", 32'(bus.done), 1);
    chk("valid_after_last", 32'(bus.out_valid), 0);
    chk("busy_in_done", 32'(bus.busy), 0);
    if (in_mode == 0 && out_mode == 0) chk("latency", 32'(ticks), 32'(2*n + 1));
    tick();
    chk("done_clear", 32'(bus.done), 0);
    chk("rows_out_hold", 32'(bus.rows_out), 32'(c));
    chk("cols_out_hold", 32'(bus.cols_out), 32'(r));
  endtask

  task automatic bad_start(input int r, input int c, input int exp_ro, input int exp_co);
    bus.rows_in = DIM_W'(r);
    bus.cols_in = DIM_W'(c);
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("err_pulse", 32'(bus.err), 1);
    chk("err_in_ready", 32'(bus.in_ready), 0);
    chk("err_busy", 32'(bus.busy), 0);
    chk("err_rows_out", 32'(bus.rows_out), 32'(exp_ro));
    chk("err_cols_out", 32'(bus.cols_out), 32'(exp_co));
    tick();
    chk("err_clear", 32'(bus.err), 0);
    chk("err_busy_after", 32'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int c;
    bus.start = 1'b0; bus.rows_in = '0; bus.cols_in = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    #2;
    chk("reset_state", all_outs(), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_after_reset", all_outs(), 0);

    // 2x3 source 1..6
    for (int i = 0; i < 6; i++) src_mem[i] = DATA_WIDTH'(i + 1);
    run_job(2, 3, 0, 0, 1'b0, -1);

    // 5x5 source 0..24 with toggling out_ready
    for (int i = 0; i < 25; i++) src_mem[i] = DATA_WIDTH'(i);
    run_job(5, 5, 0, 1, 1'b0, -1);

    // illegal dimensions; dims from 5x5 job must persist
    bad_start(0, 3, 5, 5);
    bad_start(2, 6, 5, 5);

    // 3x2 with in_valid gaps
    for (int i = 0; i < 6; i++) src_mem[i] = DATA_WIDTH'($urandom);
    run_job(3, 2, 1, 0, 1'b0, -1);

    // 4x4 aborted mid-emit by reset
    for (int i = 0; i < 16; i++) src_mem[i] = DATA_WIDTH'($urandom);
    run_job(4, 4, 0, 0, 1'b0, 5);

    // 1x1 value 7 after reset
    src_mem[0] = DATA_WIDTH'(7);
    run_job(1, 1, 0, 0, 1'b0, -1);

    // start pulsed during load must be ignored
    for (int i = 0; i < 8; i++) src_mem[i] = DATA_WIDTH'($urandom);
    run_job(2, 4, 0, 0, 1'b1, -1);

    // randomized jobs
    for (int j = 0; j < 12; j++) begin
      r = int'($urandom_range(1, MAX_DIM));
      c = int'($urandom_range(1, MAX_DIM));
      for (int i = 0; i < r*c; i++) src_mem[i] = DATA_WIDTH'($urandom);
      run_job(r, c, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
